// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encoding and FSM state type for the HI/LO mul/div unit
package hilo_pkg;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

endpackage

// File: rtl/hilo_seq_core.sv
// rtl/hilo_seq_core.sv - iterative unsigned shift-add multiply / restoring divide datapath
module hilo_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] raw_hi,
    output logic [WIDTH-1:0] raw_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   div_rem;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opb_q};
        div_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];

        acc_d = acc_q;
        opb_d = opb_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, op_a};
            opb_d = op_b;
            div_d = is_div;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                acc_d = {div_rem, acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign raw_hi = acc_q[2*WIDTH-1:WIDTH];
    assign raw_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with sequential signed/unsigned multiply and divide
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sgn_q, sgn_d;
    logic             div_q, div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] a_q, a_d;

    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             core_load, core_step, core_last;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // Minimum value negates to itself, which is exactly its unsigned magnitude.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        core_load = (state_q == IDLE) && start;
        core_step = (state_q == RUN);
    end

    hilo_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (op[1]),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .last   (core_last),
        .raw_hi (core_hi),
        .raw_lo (core_lo)
    );

    always_comb begin
        prod = {core_hi, core_lo};
        quo  = core_lo;
        rem  = core_hi;
        if (sgn_q && (neg_a_q ^ neg_b_q)) begin
            prod = -prod;
            quo  = -quo;
        end
        if (sgn_q && neg_a_q) begin
            rem = -rem;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn_d    = sgn_q;
        div_d    = div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    sgn_d    = op_signed;
                    div_d    = op[1];
                    neg_a_d  = a_neg;
                    neg_b_d  = b_neg;
                    b_zero_d = (b == '0);
                    a_d      = a;
                end
            end
            RUN: begin
                if (core_last) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (div_q && b_zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            sgn_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sgn_q    <= sgn_d;
            div_q    <= div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized and directed checks of hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             wr_hi, wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy, done;
    logic [WIDTH-1:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_hi, exp_lo;

    hilo_muldiv #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Architectural result {HI, LO} computed with plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sp;
        logic [63:0] up;
        logic signed [31:0] q, r;
        case (o)
            2'd0: begin
                up = {32'b0, x} * {32'b0, y};
                return up;
            end
            2'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int disturb, input bit co_wr);
        logic [63:0] r;
        r = ref_op(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        if (co_wr) begin
            wr_hi = 1'b1;
            wr_data = x ^ 32'h5A5A_5A5A;
        end
        tick();
        if (co_wr) begin
            exp_hi = x ^ 32'h5A5A_5A5A;
            chk("co_write_hi", 64'(hi_out), 64'(exp_hi));
        end
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        for (int i = 0; i <= WIDTH; i++) begin
            chk("busy_high", 64'(busy), 64'd1);
            chk("done_low", 64'(done), 64'd0);
            chk("hi_hold", 64'(hi_out), 64'(exp_hi));
            chk("lo_hold", 64'(lo_out), 64'(exp_lo));
            if (i == disturb) begin
                start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = $urandom;
            end else begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            tick();
        end
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk("busy_end", 64'(busy), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        chk("result_hi", 64'(hi_out), 64'(exp_hi));
        chk("result_lo", 64'(lo_out), 64'(exp_lo));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
        wr_hi = 1'($urandom); wr_lo = 1'($urandom); wr_data = $urandom;
        repeat (3) tick();
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        exp_hi = '0; exp_lo = '0;
        tick();

        wr_hi = 1'b1; wr_data = 32'h1234_5678;
        tick();
        wr_hi = 1'b0;
        exp_hi = 32'h1234_5678;
        chk("mthi_hi", 64'(hi_out), 64'(exp_hi));
        chk("mthi_lo", 64'(lo_out), 64'd0);
        wr_lo = 1'b1; wr_data = 32'h9ABC_DEF0;
        tick();
        wr_lo = 1'b0;
        exp_lo = 32'h9ABC_DEF0;
        chk("mtlo_lo", 64'(lo_out), 64'(exp_lo));
        chk("mtlo_hi", 64'(hi_out), 64'(exp_hi));

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        chk("multu_max_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo", 64'(lo_out), 64'h0000_0000_0000_0001);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
        chk("mult_neg_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFEB);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        chk("mult_min_hi", 64'(hi_out), 64'h0000_0000_4000_0000);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        chk("div_neg_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
        run_op(2'd2, 32'd7, 32'd0, -1, 1'b0);
        chk("divu_zero_hi", 64'(hi_out), 64'd7);
        chk("divu_zero_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFF);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        chk("div_wrap_lo", 64'(lo_out), 64'h0000_0000_8000_0000);
        chk("div_wrap_hi", 64'(hi_out), 64'd0);
        run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 5, 1'b0);
        run_op(2'd2, 32'd1000, 32'd7, 20, 1'b1);
        run_op(2'd3, 32'hFFFF_FFFB, 32'd0, -1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            logic [1:0]  ro;
            logic [31:0] rx, ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'hFFFF_FFFF;
                2: rx = 32'h8000_0000;
                3: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, rx, ry, (n % 4 == 0) ? 3 + n : -1, n[0]);
        end

        op = 2'd2; a = $urandom; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("midrst_hi", 64'(hi_out), 64'd0);
        chk("midrst_lo", 64'(lo_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            chk("midrst_no_done", 64'(done), 64'd0);
            chk("midrst_idle", 64'(busy), 64'd0);
        end
        run_op(2'd0, 32'd6, 32'd7, -1, 1'b0);
        chk("post_rst_lo", 64'(lo_out), 64'd42);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
